// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: round-robin sharing of one ALU operation port between N_REQ requesters.
// One operation in flight; local arg_number check, result timeout and unsolicited-result counting.
module alu_op_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned RES_W   = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*3-1:0]  req_cmd,
    input  logic [N_REQ*4-1:0]  req_arg_number,
    input  logic [N_REQ*80-1:0] req_data,
    output logic                alu_op_valid,
    input  logic                alu_op_ready,
    output logic [2:0]          alu_cmd,
    output logic [3:0]          alu_arg_number,
    output logic [79:0]         alu_data,
    input  logic                alu_res_valid,
    input  logic [RES_W-1:0]    alu_res_data,
    input  logic [7:0]          alu_res_status,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [RES_W-1:0]    rsp_data,
    output logic [7:0]          rsp_status,
    output logic [1:0]          rsp_err,
    output logic                busy,
    output logic [7:0]          drop_cnt
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CAND_W = IDX_W + 1;
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e state_q, state_d;

    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  owner_q;
    logic [TMR_W-1:0]  timer_q;
    logic [2:0]        alu_cmd_q;
    logic [3:0]        alu_arg_number_q;
    logic [79:0]       alu_data_q;
    logic [RES_W-1:0]  rsp_data_q;
    logic [7:0]        rsp_status_q;
    logic [1:0]        rsp_err_q;
    logic [7:0]        drop_cnt_q;

    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [CAND_W-1:0] cand;
    logic [2:0]        sel_cmd;
    logic [3:0]        sel_arg_number;
    logic [79:0]       sel_data;
    logic              arg_ok;
    logic              timer_expired;
    logic [IDX_W-1:0]  owner_next;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CAND_W'(k);
            if (cand >= CAND_W'(N_REQ)) begin
                cand = cand - CAND_W'(N_REQ);
            end
            if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_cmd        = req_cmd[grant_idx*3 +: 3];
        sel_arg_number = req_arg_number[grant_idx*4 +: 4];
        sel_data       = req_data[grant_idx*80 +: 80];
        arg_ok         = (sel_arg_number >= 4'd2) && (sel_arg_number <= 4'd10);
        timer_expired  = (timer_q == TMR_LAST);
        owner_next     = (owner_q == IDX_MAX) ? '0 : owner_q + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d = arg_ok ? StIssue : StResp;
                end
            end
            StIssue: begin
                if (alu_op_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (alu_res_valid || timer_expired) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        alu_op_valid = (state_q == StIssue);
        busy         = (state_q != StIdle);
        if (state_q == StIdle && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state_q == StResp) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q         <= '0;
            owner_q          <= '0;
            timer_q          <= '0;
            alu_cmd_q        <= '0;
            alu_arg_number_q <= '0;
            alu_data_q       <= '0;
            rsp_data_q       <= '0;
            rsp_status_q     <= '0;
            rsp_err_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        owner_q          <= grant_idx;
                        alu_cmd_q        <= sel_cmd;
                        alu_arg_number_q <= sel_arg_number;
                        alu_data_q       <= sel_data;
                        if (!arg_ok) begin
                            rsp_err_q    <= 2'b10;
                            rsp_data_q   <= '0;
                            rsp_status_q <= '0;
                        end
                    end
                end
                StIssue: begin
                    if (alu_op_ready) begin
                        timer_q <= '0;
                    end
                end
                StWait: begin
                    // A result arriving on the expiry cycle still wins over the timeout.
                    if (alu_res_valid) begin
                        rsp_err_q    <= 2'b00;
                        rsp_data_q   <= alu_res_data;
                        rsp_status_q <= alu_res_status;
                    end else if (timer_expired) begin
                        rsp_err_q    <= 2'b01;
                        rsp_data_q   <= '0;
                        rsp_status_q <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                StResp:  rr_ptr_q <= owner_next;
                default: ;
            endcase
        end
    end

    // Results outside WAIT have no owner; count them and discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (alu_res_valid && state_q != StWait && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign alu_cmd        = alu_cmd_q;
    assign alu_arg_number = alu_arg_number_q;
    assign alu_data       = alu_data_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_status     = rsp_status_q;
    assign rsp_err        = rsp_err_q;
    assign drop_cnt       = drop_cnt_q;

    req_ready_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    rsp_valid_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid));
    op_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
        (alu_op_valid && !alu_op_ready) |=>
        (alu_op_valid && $stable({alu_cmd, alu_arg_number, alu_data})));

endmodule

// File: tb/tb_alu_op_arbiter.sv
// tb_alu_op_arbiter: directed scenarios plus randomized traffic, checked against a
// transaction-level model of round-robin grant order, response timing and payload.
module tb_alu_op_arbiter;

    localparam int N  = 4;
    localparam int RW = 16;
    localparam int TO = 8;
    localparam int NEVER = 1 << 30;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*3-1:0]  req_cmd = '0;
    logic [N*4-1:0]  req_arg_number = '0;
    logic [N*80-1:0] req_data = '0;
    logic            alu_op_valid;
    logic            alu_op_ready = 1'b0;
    logic [2:0]      alu_cmd;
    logic [3:0]      alu_arg_number;
    logic [79:0]     alu_data;
    logic            alu_res_valid = 1'b0;
    logic [RW-1:0]   alu_res_data = '0;
    logic [7:0]      alu_res_status = '0;
    logic [N-1:0]    rsp_valid;
    logic [RW-1:0]   rsp_data;
    logic [7:0]      rsp_status;
    logic [1:0]      rsp_err;
    logic            busy;
    logic [7:0]      drop_cnt;

    always #5 clk = ~clk;

    alu_op_arbiter #(.N_REQ(N), .RES_W(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_arg_number(req_arg_number), .req_data(req_data),
        .alu_op_valid(alu_op_valid), .alu_op_ready(alu_op_ready), .alu_cmd(alu_cmd),
        .alu_arg_number(alu_arg_number), .alu_data(alu_data),
        .alu_res_valid(alu_res_valid), .alu_res_data(alu_res_data),
        .alu_res_status(alu_res_status),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .rsp_err(rsp_err), .busy(busy), .drop_cnt(drop_cnt)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester side: pending operations and their fields.
    logic [N-1:0] pend = '0;
    logic [2:0]   rq_cmd[N];
    logic [3:0]   rq_argn[N];
    logic [79:0]  rq_data[N];

    // Model of the single in-flight transaction.
    int cyc = 0, rr = 0, free_from = 0, grant_cyc = 0, hs_cyc = 0;
    int exp_rsp_cyc = NEVER, res_delay = -1, owner = 0, exp_drop = 0;
    bit busy_m = 0, cur_bad = 0, hs_done = 0, drop_pulse = 0, dropping = 0;
    bit auto_req = 0, keep_all = 0, fix_res = 0;
    int rdy_mode = 1;   // 0 random, 1 always, 2 never
    int res_mode = 0;   // -2 random delay, -1 never respond, else fixed delay
    logic [RW-1:0] fix_val = '0;
    logic [2:0]    cur_cmd;
    logic [3:0]    cur_argn;
    logic [79:0]   cur_data;
    logic [RW-1:0] exp_data;
    logic [7:0]    exp_status;
    logic [1:0]    exp_err;

    typedef struct {
        int        owner;
        logic [1:0] err;
        logic [15:0] data;
        int        lat;
    } rsp_t;
    rsp_t rsp_log[$];
    int   grant_log[$];

    function automatic logic [79:0] rand80();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[79:0];
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) if (pend[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic post(input int i, input logic [2:0] c, input logic [3:0] a,
                        input logic [79:0] d);
        pend[i] = 1'b1;
        rq_cmd[i] = c;
        rq_argn[i] = a;
        rq_data[i] = d;
    endtask

    task automatic post_rand(input int i, input bit good);
        logic [3:0] a;
        if (good || $urandom_range(0, 4) != 0) a = 4'($urandom_range(2, 10));
        else if ($urandom_range(0, 1) == 0) a = 4'($urandom_range(0, 1));
        else a = 4'($urandom_range(11, 15));
        post(i, 3'($urandom_range(0, 7)), a, rand80());
    endtask

    task automatic tick();
        logic [N-1:0] exp_rdy, exp_rsp;
        bit exp_opv;
        int g;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && keep_all) post_rand(i, 1'b1);
            else if (!pend[i] && auto_req && $urandom_range(0, 2) == 0) post_rand(i, 1'b0);
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_cmd[i*3 +: 3] = pend[i] ? rq_cmd[i] : 3'($urandom);
            req_arg_number[i*4 +: 4] = pend[i] ? rq_argn[i] : 4'($urandom);
            req_data[i*80 +: 80] = pend[i] ? rq_data[i] : rand80();
        end
        alu_op_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 :
                       ($urandom_range(0, 2) != 0);
        alu_res_valid = 1'b0;
        alu_res_data = RW'($urandom);
        alu_res_status = 8'($urandom);
        if (busy_m && hs_done && res_delay >= 0 && cyc == hs_cyc + 1 + res_delay) begin
            alu_res_valid = 1'b1;
            if (fix_res) alu_res_data = fix_val;
            exp_data = alu_res_data;
            exp_status = alu_res_status;
        end
        if (drop_pulse) begin
            alu_res_valid = 1'b1;
            drop_pulse = 0;
            dropping = 1;
        end
        #1;
        check_eq("busy", busy, busy_m && cyc > grant_cyc);
        exp_rdy = '0;
        g = -1;
        if (!busy_m && cyc >= free_from && pend != '0) begin
            g = pick();
            exp_rdy[g] = 1'b1;
        end
        check_eq("req_ready", req_ready, exp_rdy);
        if (req_ready != '0) grant_log.push_back(idx_of(req_ready));
        if (g >= 0) begin
            owner = g;
            cur_cmd = rq_cmd[g];
            cur_argn = rq_argn[g];
            cur_data = rq_data[g];
            cur_bad = (rq_argn[g] < 2) || (rq_argn[g] > 10);
            grant_cyc = cyc;
            hs_done = 0;
            busy_m = 1;
            pend[g] = 1'b0;
            exp_rsp_cyc = cur_bad ? cyc + 1 : NEVER;
            if (cur_bad) begin
                exp_err = 2'b10;
                exp_data = '0;
                exp_status = '0;
            end
        end
        exp_opv = busy_m && !cur_bad && !hs_done && cyc > grant_cyc;
        check_eq("alu_op_valid", alu_op_valid, exp_opv);
        if (exp_opv) begin
            check_eq("alu_cmd", alu_cmd, cur_cmd);
            check_eq("alu_arg_number", alu_arg_number, cur_argn);
            check_eq("alu_data", alu_data, cur_data);
            if (alu_op_ready) begin
                hs_done = 1;
                hs_cyc = cyc;
                if (res_mode == -2) begin
                    res_delay = $urandom_range(0, 9);
                    if (res_delay >= TO) res_delay = -1;
                end else begin
                    res_delay = res_mode;
                end
                exp_rsp_cyc = (res_delay >= 0) ? cyc + 2 + res_delay : cyc + 1 + TO;
                exp_err = (res_delay >= 0) ? 2'b00 : 2'b01;
                exp_data = '0;
                exp_status = '0;
            end
        end
        exp_rsp = '0;
        if (busy_m && cyc == exp_rsp_cyc) exp_rsp[owner] = 1'b1;
        check_eq("rsp_valid", rsp_valid, exp_rsp);
        if (exp_rsp != '0) begin
            check_eq("rsp_data", rsp_data, exp_data);
            check_eq("rsp_status", rsp_status, exp_status);
            check_eq("rsp_err", rsp_err, exp_err);
            rsp_log.push_back('{idx_of(rsp_valid), rsp_err, rsp_data, cyc - grant_cyc});
            busy_m = 0;
            free_from = cyc + 1;
            rr = (owner + 1) % N;
        end
        check_eq("drop_cnt", drop_cnt, exp_drop);
        if (dropping) begin
            if (exp_drop < 255) exp_drop++;
            dropping = 0;
        end
    endtask

    task automatic do_reset();
        pend = '0;
        req_valid = '0;
        alu_res_valid = 1'b0;
        alu_op_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_ctl", {req_ready, alu_op_valid, rsp_valid, rsp_err, busy, drop_cnt,
                             rsp_data, rsp_status}, '0);
        check_eq("rst_alu", {alu_cmd, alu_arg_number, alu_data}, '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        busy_m = 0;
        hs_done = 0;
        rr = 0;
        free_from = 0;
        exp_drop = 0;
        exp_rsp_cyc = NEVER;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (pend != '0 || busy_m); k++) tick();
        check_eq("drain_done", {pend, busy_m}, '0);
    endtask

    initial begin
        do_reset();

        // Single add from requester 0 answered immediately.
        rdy_mode = 1; res_mode = 0; fix_res = 1; fix_val = 16'h0003;
        rsp_log.delete();
        post(0, 3'd4, 4'd2, 80'h0201);
        repeat (6) tick();
        check_eq("t1_count", rsp_log.size(), 1);
        if (rsp_log.size() > 0) begin
            check_eq("t1_owner", rsp_log[0].owner, 0);
            check_eq("t1_data", rsp_log[0].data, 16'h0003);
            check_eq("t1_err", rsp_log[0].err, 2'b00);
            check_eq("t1_latency", rsp_log[0].lat, 3);
        end
        fix_res = 0;

        // All requesters continuously valid.
        do_reset();
        grant_log.delete();
        keep_all = 1;
        repeat (24) tick();
        keep_all = 0;
        drain();
        check_eq("t2_grants", grant_log.size() >= 5, 1'b1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check_eq("t2_order", grant_log[k], k % N);

        // Bad arg_number from requester 2, below and above range.
        rsp_log.delete();
        post(2, 3'd4, 4'd1, rand80());
        repeat (4) tick();
        post(2, 3'd1, 4'd11, rand80());
        repeat (4) tick();
        check_eq("t3_count", rsp_log.size(), 2);
        foreach (rsp_log[k]) begin
            check_eq("t3_owner", rsp_log[k].owner, 2);
            check_eq("t3_err", rsp_log[k].err, 2'b10);
            check_eq("t3_latency", rsp_log[k].lat, 1);
        end

        // ALU never answers: timeout, then the next request is served.
        rsp_log.delete();
        res_mode = -1;
        post(1, 3'd5, 4'd3, rand80());
        tick();
        post(3, 3'd2, 4'd4, rand80());
        repeat (26) tick();
        check_eq("t4_count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            check_eq("t4_owner0", rsp_log[0].owner, 1);
            check_eq("t4_err0", rsp_log[0].err, 2'b01);
            check_eq("t4_latency", rsp_log[0].lat, TO + 2);
            check_eq("t4_owner1", rsp_log[1].owner, 3);
        end

        // ALU stalls for 20+ cycles, then an unsolicited result in IDLE.
        res_mode = 0; rdy_mode = 2;
        post(0, 3'd6, 4'd5, rand80());
        repeat (22) tick();
        check_eq("t5_stalled", alu_op_valid, 1'b1);
        rdy_mode = 1;
        repeat (5) tick();
        rsp_log.delete();
        drop_pulse = 1;
        repeat (2) tick();
        check_eq("t5_drop", drop_cnt, 8'd1);
        check_eq("t5_no_rsp", rsp_log.size(), 0);

        // Reset while waiting for a result; the late result is dropped.
        res_mode = -1;
        post(0, 3'd3, 4'd2, rand80());
        repeat (5) tick();
        check_eq("t6_waiting", busy, 1'b1);
        do_reset();
        drop_pulse = 1;
        repeat (2) tick();
        check_eq("t6_drop", drop_cnt, 8'd1);

        // Randomized traffic.
        auto_req = 1; rdy_mode = 0; res_mode = -2;
        repeat (3000) tick();
        auto_req = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
